i2c_slave_regfile: RTL and testbench

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_slave_regfile.sv | 163 ++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regfile
// Description : Byte-level I2C slave back end. Answers ADDRESSNUM slave
//               addresses, each with its own NBYTES register bank. A write
//               transaction starts with a pointer byte; subsequent bytes
//               stream through a shared auto-incrementing pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
  parameter int ADDRESSLENGTH = 7,
  parameter int ADDRESSNUM    = 2,
  parameter int NBYTES        = 4
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0]   AddressList,
  input  logic [ADDRESSLENGTH-1:0]              DirectionBuffer,
  input  logic                                  AddrValid,
  input  logic                                  RorW,
  input  logic                                  WriteStrobe,
  input  logic                                  ReadStrobe,
  input  logic                                  StopDetected,
  input  logic [7:0]                            InputBuffer,
  output logic [7:0]                            OutputBuffer,
  output logic                                  DataValid,
  output logic                                  AddressFound,
  output logic [((ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1)-1:0] AddressID,
  output logic                                  PtrError,
  output logic [8*NBYTES*ADDRESSNUM-1:0]        Data
);

  localparam int IDW   = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1;
  localparam int PTRW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DATAW = 8*NBYTES*ADDRESSNUM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;     // XFER direction: 1 = master writes
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [DATAW-1:0]  data_q, data_d;
  logic [7:0]        obuf_q, obuf_d;
  logic              dv_q, dv_d;
  logic              found_q, found_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              perr_q, perr_d;

  logic              w_match;
  logic [IDW-1:0]    w_match_id;
  logic [PTRW-1:0]   w_ptr_inc;
  int                w_idx;

  // Address compare: scan high to low so the lowest matching index wins
  always_comb begin
    w_match    = 1'b0;
    w_match_id = '0;
    for (int i = ADDRESSNUM-1; i >= 0; i--) begin
      if (AddressList[ADDRESSLENGTH*i +: ADDRESSLENGTH] == DirectionBuffer) begin
        w_match    = 1'b1;
        w_match_id = IDW'(i);
      end
    end
  end

  // Pointer wrap and flat-memory bit offset of the currently addressed byte
  always_comb begin
    w_ptr_inc = (ptr_q == PTRW'(NBYTES-1)) ? '0 : ptr_q + 1'b1;
    w_idx     = 8*(NBYTES*int'(id_q) + int'(ptr_q));
  end

  // Next-state and datapath: AddrValid beats STOP, STOP beats byte strobes
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    obuf_d  = obuf_q;
    dv_d    = 1'b0;
    found_d = found_q;
    id_d    = id_q;
    perr_d  = perr_q;

    if (AddrValid) begin
      if (w_match) begin
        found_d = 1'b1;
        id_d    = w_match_id;
        write_d = RorW;
        state_d = RorW ? PTR : XFER;
      end else begin
        found_d = 1'b0;
        state_d = IDLE;
      end
    end else if (StopDetected) begin
      found_d = 1'b0;
      state_d = IDLE;
    end else if (WriteStrobe ^ ReadStrobe) begin
      case (state_q)
        PTR: begin
          if (WriteStrobe) begin
            if (32'(InputBuffer) >= 32'(NBYTES)) begin
              ptr_d  = '0;
              perr_d = 1'b1;
            end else begin
              ptr_d  = PTRW'(InputBuffer);
            end
            write_d = 1'b1;
            state_d = XFER;
          end
        end
        XFER: begin
          if (write_q && WriteStrobe) begin
            data_d[w_idx +: 8] = InputBuffer;
            ptr_d              = w_ptr_inc;
          end else if (!write_q && ReadStrobe) begin
            obuf_d = data_q[w_idx +: 8];
            dv_d   = 1'b1;
            ptr_d  = w_ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      ptr_q   <= '0;
      data_q  <= '0;
      obuf_q  <= '0;
      dv_q    <= 1'b0;
      found_q <= 1'b0;
      id_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      obuf_q  <= obuf_d;
      dv_q    <= dv_d;
      found_q <= found_d;
      id_q    <= id_d;
      perr_q  <= perr_d;
    end
  end

  assign OutputBuffer = obuf_q;
  assign DataValid    = dv_q;
  assign AddressFound = found_q;
  assign AddressID    = id_q;
  assign PtrError     = perr_q;
  assign Data         = data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regfile
// Description : Directed bench for i2c_slave_regfile with default parameters
//               and AddressList = {7'h51, 7'h50}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [13:0] AddressList;
  logic [6:0]  DirectionBuffer;
  logic        AddrValid, RorW, WriteStrobe, ReadStrobe, StopDetected;
  logic [7:0]  InputBuffer;
  logic [7:0]  OutputBuffer;
  logic        DataValid, AddressFound, PtrError;
  logic [0:0]  AddressID;
  logic [63:0] Data;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_slave_regfile #(.ADDRESSLENGTH(7), .ADDRESSNUM(2), .NBYTES(4)) u_dut (
    .Clk(Clk), .Reset(Reset), .AddressList(AddressList),
    .DirectionBuffer(DirectionBuffer), .AddrValid(AddrValid), .RorW(RorW),
    .WriteStrobe(WriteStrobe), .ReadStrobe(ReadStrobe),
    .StopDetected(StopDetected), .InputBuffer(InputBuffer),
    .OutputBuffer(OutputBuffer), .DataValid(DataValid),
    .AddressFound(AddressFound), .AddressID(AddressID),
    .PtrError(PtrError), .Data(Data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Each stimulus task drives on a falling edge and returns on the next one,
  // so exactly one rising edge samples the strobe.
  task automatic addr(input logic [6:0] a, input logic rw);
    @(negedge Clk);
    DirectionBuffer = a; RorW = rw; AddrValid = 1'b1;
    @(negedge Clk);
    AddrValid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge Clk);
    InputBuffer = b; WriteStrobe = 1'b1;
    @(negedge Clk);
    WriteStrobe = 1'b0;
  endtask

  task automatic rd();
    @(negedge Clk);
    ReadStrobe = 1'b1;
    @(negedge Clk);
    ReadStrobe = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; AddressList = {7'h51, 7'h50};
    DirectionBuffer = '0; AddrValid = 0; RorW = 0; WriteStrobe = 0;
    ReadStrobe = 0; StopDetected = 0; InputBuffer = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Reset state
    chk("rst_data",  Data, 64'h0);
    chk("rst_found", AddressFound, 1'b0);
    chk("rst_perr",  PtrError, 1'b0);
    chk("rst_dv",    DataValid, 1'b0);
    chk("rst_obuf",  OutputBuffer, 8'h00);

    // V-1: pointer 2, three bytes with wrap
    addr(7'h50, 1'b1);
    chk("v1_found", AddressFound, 1'b1);
    chk("v1_id",    AddressID, 1'b0);
    wr(8'h02); wr(8'hAA); wr(8'hBB); wr(8'hCC);
    chk("v1_data",  Data, 64'h00000000_BBAA00CC);

    // V-2: repeated start read from retained pointer 1
    addr(7'h50, 1'b0);
    rd();
    chk("v2_dv0",   DataValid, 1'b1);
    chk("v2_rd0",   OutputBuffer, 8'h00);
    @(negedge Clk);
    chk("v2_dvoff", DataValid, 1'b0);
    rd();
    chk("v2_rd1",   OutputBuffer, 8'hAA);
    rd();
    chk("v2_dv2",   DataValid, 1'b1);
    chk("v2_rd2",   OutputBuffer, 8'hBB);

    // V-3: out-of-range pointer on bank 1
    addr(7'h51, 1'b1);
    chk("v3_id",    AddressID, 1'b1);
    wr(8'h07);
    chk("v3_perr",  PtrError, 1'b1);
    wr(8'h11);
    chk("v3_data",  Data, 64'h00000011_BBAA00CC);

    // V-4: unmatched address, strobes ignored
    addr(7'h23, 1'b1);
    chk("v4_found", AddressFound, 1'b0);
    wr(8'h99);
    rd();
    chk("v4_dv",    DataValid, 1'b0);
    chk("v4_data",  Data, 64'h00000011_BBAA00CC);

    // Simultaneous write and read strobes are both ignored
    addr(7'h50, 1'b1);
    wr(8'h01);
    @(negedge Clk);
    InputBuffer = 8'h77; WriteStrobe = 1'b1; ReadStrobe = 1'b1;
    @(negedge Clk);
    WriteStrobe = 1'b0; ReadStrobe = 1'b0;
    chk("both_data", Data, 64'h00000011_BBAA00CC);
    chk("both_dv",   DataValid, 1'b0);

    // V-5: STOP with a write strobe, then read resumes at pointer 1
    @(negedge Clk);
    InputBuffer = 8'h55; WriteStrobe = 1'b1; StopDetected = 1'b1;
    @(negedge Clk);
    WriteStrobe = 1'b0; StopDetected = 1'b0;
    chk("v5_found", AddressFound, 1'b0);
    chk("v5_data",  Data, 64'h00000011_BBAA00CC);
    addr(7'h50, 1'b0);
    rd();
    chk("v5_rd0",   OutputBuffer, 8'h00);
    rd();
    chk("v5_rd1",   OutputBuffer, 8'hAA);

    // AddrValid wins over a coincident STOP
    @(negedge Clk);
    DirectionBuffer = 7'h51; RorW = 1'b0; AddrValid = 1'b1; StopDetected = 1'b1;
    @(negedge Clk);
    AddrValid = 1'b0; StopDetected = 1'b0;
    chk("prio_found", AddressFound, 1'b1);
    chk("prio_id",    AddressID, 1'b1);

    // V-6: asynchronous reset between edges during a write
    addr(7'h51, 1'b1);
    wr(8'h00);
    @(negedge Clk);
    InputBuffer = 8'hEE; WriteStrobe = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk("v6_data",  Data, 64'h0);
    chk("v6_found", AddressFound, 1'b0);
    chk("v6_id",    AddressID, 1'b0);
    chk("v6_obuf",  OutputBuffer, 8'h00);
    chk("v6_perr",  PtrError, 1'b0);
    @(negedge Clk);
    WriteStrobe = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("v6_after", Data, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
